// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, register-reference bits,
// sequencer states and the control-strobe bundle consumed by the datapath.
package cpu_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_BUN = 3'b100;
    localparam logic [2:0] OP_RSV = 3'b101;
    localparam logic [2:0] OP_ISZ = 3'b110;
    localparam logic [2:0] OP_REG = 3'b111;

    localparam int unsigned IR_I   = 15;
    localparam int unsigned RR_CLA = 11;
    localparam int unsigned RR_CLE = 10;
    localparam int unsigned RR_CMA = 9;
    localparam int unsigned RR_LDI = 8;
    localparam int unsigned RR_CIR = 7;
    localparam int unsigned RR_CIL = 6;
    localparam int unsigned RR_INC = 5;
    localparam int unsigned RR_HLT = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch0,
        StFetch1,
        StDecode,
        StIndirect,
        StExec,
        StHalt,
        StErr
    } state_e;

    typedef struct packed {
        logic fetch;
        logic read;
        logic execute;
        logic is_ind;
        logic is_dir;
        logic clr_ac;
        logic clr_e;
        logic comp_ac;
        logic load_ac;
        logic cir_r;
        logic cir_l;
        logic inc_ac;
        logic add;
        logic load;
        logic store;
        logic branch;
        logic isz;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: maps an instruction word to its operation
// strobes; register-reference bits are priority-encoded, highest bit wins.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output ctrl_t       ctrl_o,
    output logic        is_mem_o,
    output logic        is_reg_o,
    output logic        is_hlt_o
);

    // Bits 4:1 carry no register-reference operation.
    logic unused_ir;
    assign unused_ir = ^ir_i[4:1];

    always_comb begin
        ctrl_o   = '0;
        is_mem_o = 1'b0;
        is_reg_o = 1'b0;
        is_hlt_o = 1'b0;
        case (ir_i[14:12])
            OP_ADD: begin ctrl_o.add    = 1'b1; is_mem_o = 1'b1; end
            OP_LDA: begin ctrl_o.load   = 1'b1; is_mem_o = 1'b1; end
            OP_STA: begin ctrl_o.store  = 1'b1; is_mem_o = 1'b1; end
            OP_BUN: begin ctrl_o.branch = 1'b1; is_mem_o = 1'b1; end
            OP_ISZ: begin ctrl_o.isz    = 1'b1; is_mem_o = 1'b1; end
            OP_REG: begin
                is_reg_o = 1'b1;
                if (ir_i[RR_CLA])      ctrl_o.clr_ac  = 1'b1;
                else if (ir_i[RR_CLE]) ctrl_o.clr_e   = 1'b1;
                else if (ir_i[RR_CMA]) ctrl_o.comp_ac = 1'b1;
                else if (ir_i[RR_LDI]) ctrl_o.load_ac = 1'b1;
                else if (ir_i[RR_CIR]) ctrl_o.cir_r   = 1'b1;
                else if (ir_i[RR_CIL]) ctrl_o.cir_l   = 1'b1;
                else if (ir_i[RR_INC]) ctrl_o.inc_ac  = 1'b1;
                else if (ir_i[RR_HLT]) is_hlt_o       = 1'b1;
            end
            default: ;  // OP_NOP and OP_RSV decode to nothing
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: steps fetch/decode/indirect/execute, holds execute
// strobes until the datapath completes, and traps execute hangs.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned EX_TIMEOUT = 15,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             i_clr_reg,
    input  logic             i_start,
    input  logic [15:0]      i_ir,
    input  logic             i_ex_done,
    output logic             o_fetch,
    output logic             o_read,
    output logic             o_execute,
    output logic             o_is_ind,
    output logic             o_is_dir,
    output logic             o_clr_ac,
    output logic             o_clr_e,
    output logic             o_comp_ac,
    output logic             o_load_ac,
    output logic             o_cir_r,
    output logic             o_cir_l,
    output logic             o_inc_ac,
    output logic             o_add,
    output logic             o_load,
    output logic             o_store,
    output logic             o_branch,
    output logic             o_isz,
    output logic [2:0]       o_sc,
    output logic             o_halted,
    output logic             o_err,
    output logic [CNT_W-1:0] o_instr_cnt
);

    localparam int unsigned ToW = (EX_TIMEOUT > 1) ? $clog2(EX_TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [15:0]        ir_q, ir_d;
    logic [ToW-1:0]     to_q, to_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t              ctrl_q, ctrl_d, dec_ctrl;
    logic [2:0]         sc_q, sc_d;
    logic               halted_q, halted_d, err_q, err_d;
    logic               is_mem, is_reg, is_hlt;

    // Decode the word that will be in ir_q next cycle so outputs can be registered.
    instr_decoder u_dec (
        .ir_i     (ir_d),
        .ctrl_o   (dec_ctrl),
        .is_mem_o (is_mem),
        .is_reg_o (is_reg),
        .is_hlt_o (is_hlt)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        to_d    = '0;
        cnt_d   = cnt_q;
        if (state_q == StDecode) ir_d = i_ir;
        case (state_q)
            StIdle:     if (i_start) state_d = StFetch0;
            StFetch0:   state_d = StFetch1;
            StFetch1:   state_d = StDecode;
            StDecode: begin
                if (is_mem && ir_d[IR_I])  state_d = StIndirect;
                else if (is_reg && is_hlt) state_d = StHalt;
                else                       state_d = StExec;
            end
            StIndirect: state_d = StExec;
            StExec: begin
                if (!is_mem || i_ex_done) begin
                    state_d = StFetch0;
                    cnt_d   = cnt_q + 1'b1;
                end else if (to_q == ToW'(EX_TIMEOUT - 1)) begin
                    state_d = StErr;
                end else begin
                    state_d = StExec;
                    to_d    = to_q + 1'b1;
                end
            end
            default: ;  // StHalt and StErr are left only by reset
        endcase
    end

    always_comb begin
        ctrl_d   = '0;
        sc_d     = 3'd0;
        halted_d = (state_d == StHalt);
        err_d    = (state_d == StErr);
        case (state_d)
            StFetch0: begin ctrl_d.fetch = 1'b1; ctrl_d.read = 1'b1; end
            StFetch1: begin ctrl_d.fetch = 1'b1; sc_d = 3'd1; end
            StDecode: sc_d = 3'd2;
            StIndirect: begin ctrl_d.read = 1'b1; ctrl_d.is_ind = 1'b1; sc_d = 3'd3; end
            StExec: begin
                ctrl_d         = dec_ctrl;
                ctrl_d.execute = 1'b1;
                ctrl_d.is_dir  = is_mem;
                sc_d           = 3'd4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge i_clr_reg) begin
        if (i_clr_reg) begin
            state_q  <= StIdle;
            ir_q     <= '0;
            to_q     <= '0;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            sc_q     <= 3'd0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            sc_q     <= sc_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign o_fetch     = ctrl_q.fetch;
    assign o_read      = ctrl_q.read;
    assign o_execute   = ctrl_q.execute;
    assign o_is_ind    = ctrl_q.is_ind;
    assign o_is_dir    = ctrl_q.is_dir;
    assign o_clr_ac    = ctrl_q.clr_ac;
    assign o_clr_e     = ctrl_q.clr_e;
    assign o_comp_ac   = ctrl_q.comp_ac;
    assign o_load_ac   = ctrl_q.load_ac;
    assign o_cir_r     = ctrl_q.cir_r;
    assign o_cir_l     = ctrl_q.cir_l;
    assign o_inc_ac    = ctrl_q.inc_ac;
    assign o_add       = ctrl_q.add;
    assign o_load      = ctrl_q.load;
    assign o_store     = ctrl_q.store;
    assign o_branch    = ctrl_q.branch;
    assign o_isz       = ctrl_q.isz;
    assign o_sc        = sc_q;
    assign o_halted    = halted_q;
    assign o_err       = err_q;
    assign o_instr_cnt = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: expected EXEC-cycle strobes are queued at issue
// and popped by a monitor whenever o_execute is presented.
module tb_control_sequencer;

    localparam int unsigned CntW = 4;

    // Phase bits {fetch, read, execute, is_ind, is_dir}
    localparam logic [4:0] PH_F0  = 5'b11000;
    localparam logic [4:0] PH_F1  = 5'b10000;
    localparam logic [4:0] PH_IND = 5'b01010;
    localparam logic [4:0] PH_EXM = 5'b00101;
    localparam logic [4:0] PH_EXR = 5'b00100;

    // Op bits {clr_ac, clr_e, comp_ac, load_ac, cir_r, cir_l, inc_ac, add, load, store, branch, isz}
    localparam logic [11:0] S_CLA = 12'h800;
    localparam logic [11:0] S_CLE = 12'h400;
    localparam logic [11:0] S_CMA = 12'h200;
    localparam logic [11:0] S_LDI = 12'h100;
    localparam logic [11:0] S_CIR = 12'h080;
    localparam logic [11:0] S_CIL = 12'h040;
    localparam logic [11:0] S_INC = 12'h020;
    localparam logic [11:0] S_ADD = 12'h010;
    localparam logic [11:0] S_LDA = 12'h008;
    localparam logic [11:0] S_STA = 12'h004;
    localparam logic [11:0] S_BUN = 12'h002;
    localparam logic [11:0] S_ISZ = 12'h001;

    logic clk = 1'b0;
    logic i_clr_reg, i_start, i_ex_done;
    logic [15:0] i_ir;
    logic o_fetch, o_read, o_execute, o_is_ind, o_is_dir;
    logic o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac;
    logic o_add, o_load, o_store, o_branch, o_isz;
    logic [2:0] o_sc;
    logic o_halted, o_err;
    logic [CntW-1:0] o_instr_cnt;

    always #5 clk = ~clk;

    control_sequencer #(.EX_TIMEOUT(15), .CNT_W(CntW)) dut (
        .clk         (clk),
        .i_clr_reg   (i_clr_reg),
        .i_start     (i_start),
        .i_ir        (i_ir),
        .i_ex_done   (i_ex_done),
        .o_fetch     (o_fetch),
        .o_read      (o_read),
        .o_execute   (o_execute),
        .o_is_ind    (o_is_ind),
        .o_is_dir    (o_is_dir),
        .o_clr_ac    (o_clr_ac),
        .o_clr_e     (o_clr_e),
        .o_comp_ac   (o_comp_ac),
        .o_load_ac   (o_load_ac),
        .o_cir_r     (o_cir_r),
        .o_cir_l     (o_cir_l),
        .o_inc_ac    (o_inc_ac),
        .o_add       (o_add),
        .o_load      (o_load),
        .o_store     (o_store),
        .o_branch    (o_branch),
        .o_isz       (o_isz),
        .o_sc        (o_sc),
        .o_halted    (o_halted),
        .o_err       (o_err),
        .o_instr_cnt (o_instr_cnt)
    );

    logic [19:0] snap;
    assign snap = {o_sc, o_fetch, o_read, o_execute, o_is_ind, o_is_dir,
                   o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
                   o_add, o_load, o_store, o_branch, o_isz};

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;
    logic [CntW-1:0] exp_cnt;

    function automatic logic [19:0] rec(input logic [2:0] sc, input logic [4:0] ph,
                                        input logic [11:0] op);
        return {sc, ph, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every presented EXEC cycle must match the queue head.
    always @(negedge clk) begin
        if (!i_clr_reg && o_execute) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL exec_unexpected: got %h expected none at %0t", snap, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("exec_strobes", {12'd0, snap}, {12'd0, mon_exp});
            end
        end
    end

    task automatic do_reset();
        i_clr_reg = 1'b1;
        i_start   = 1'b0;
        i_ex_done = 1'b0;
        tick();
        tick();
        chk("reset_state", {6'd0, o_halted, o_err, o_instr_cnt, snap}, 32'd0);
        i_clr_reg = 1'b0;
        exp_cnt   = '0;
    endtask

    // Entry: negedge with FETCH0 visible. Exit: negedge with the post-DECODE state visible.
    task automatic fetch_phase(input logic [15:0] ir, input bit ind, input bit noise);
        i_ir      = ir;
        i_ex_done = noise;
        chk("fetch0", {12'd0, snap}, {12'd0, rec(3'd0, PH_F0, 12'h0)});
        tick();
        chk("fetch1", {12'd0, snap}, {12'd0, rec(3'd1, PH_F1, 12'h0)});
        tick();
        chk("decode", {12'd0, snap}, {12'd0, rec(3'd2, 5'b0, 12'h0)});
        tick();
        if (ind) begin
            chk("indirect", {12'd0, snap}, {12'd0, rec(3'd3, PH_IND, 12'h0)});
            tick();
        end
        i_ex_done = 1'b0;
    endtask

    task automatic instr(input logic [15:0] ir, input bit ind, input bit noise, input int n,
                         input bit mem, input logic [11:0] op);
        for (int k = 0; k < n; k++) exp_q.push_back(rec(3'd4, mem ? PH_EXM : PH_EXR, op));
        fetch_phase(ir, ind, noise);
        for (int k = 0; k < n; k++) begin
            i_ex_done = mem && (k == n - 1);
            tick();
        end
        i_ex_done = 1'b0;
        exp_cnt   = exp_cnt + 1'b1;
        chk("instr_cnt", {28'd0, o_instr_cnt}, {28'd0, exp_cnt});
    endtask

    initial begin
        i_clr_reg = 1'b1;
        i_start   = 1'b0;
        i_ex_done = 1'b0;
        i_ir      = 16'h0000;
        exp_cnt   = '0;

        do_reset();
        i_start = 1'b1;  // left high: must have no effect after leaving IDLE
        tick();
        instr(16'h7800, 1'b0, 1'b0, 1, 1'b0, S_CLA);
        i_start = 1'b0;
        instr(16'h1123, 1'b0, 1'b1, 3, 1'b1, S_ADD);  // i_ex_done high during fetch ignored
        instr(16'hC456, 1'b1, 1'b0, 1, 1'b1, S_BUN);  // done on first EXEC cycle
        instr(16'h7A21, 1'b0, 1'b0, 1, 1'b0, S_CLA);
        instr(16'h2000, 1'b0, 1'b0, 2, 1'b1, S_LDA);
        instr(16'hB000, 1'b1, 1'b0, 1, 1'b1, S_STA);
        instr(16'h6010, 1'b0, 1'b0, 1, 1'b1, S_ISZ);
        instr(16'hD000, 1'b0, 1'b0, 1, 1'b0, 12'h0);  // reserved opcode, I set
        instr(16'hF400, 1'b0, 1'b0, 1, 1'b0, S_CLE);  // I ignored for register-reference
        instr(16'h7200, 1'b0, 1'b0, 1, 1'b0, S_CMA);
        instr(16'h7100, 1'b0, 1'b0, 1, 1'b0, S_LDI);
        instr(16'h7080, 1'b0, 1'b0, 1, 1'b0, S_CIR);
        instr(16'h7040, 1'b0, 1'b0, 1, 1'b0, S_CIL);
        instr(16'h7020, 1'b0, 1'b0, 1, 1'b0, S_INC);
        instr(16'h7000, 1'b0, 1'b0, 1, 1'b0, 12'h0);
        instr(16'h701E, 1'b0, 1'b0, 1, 1'b0, 12'h0);
        instr(16'h7021, 1'b0, 1'b0, 1, 1'b0, S_INC);  // INC outranks HLT

        // Reset in the middle of a stalled EXEC clears outputs without a clock.
        exp_q.push_back(rec(3'd4, PH_EXM, S_ADD));
        exp_q.push_back(rec(3'd4, PH_EXM, S_ADD));
        fetch_phase(16'h1123, 1'b0, 1'b0);
        tick();
        @(posedge clk);
        #1;
        chk("exec_before_reset", {24'd0, o_execute, o_add, o_instr_cnt, o_sc}, {24'd0, 1'b1, 1'b1, 4'd1, 3'd4});
        #1 i_clr_reg = 1'b1;
        #1 chk("reset_async", {6'd0, o_halted, o_err, o_instr_cnt, snap}, 32'd0);
        do_reset();

        // Back-to-back NOPs wrap the 4-bit counter.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 16; i++) instr(16'h0000, 1'b0, 1'b0, 1, 1'b0, 12'h0);

        // HLT: halts, no count, i_start ignored.
        fetch_phase(16'h7001, 1'b0, 1'b0);
        chk("halt_state", {6'd0, o_halted, o_err, o_instr_cnt, snap},
            {6'd0, 1'b1, 1'b0, exp_cnt, 20'd0});
        i_start = 1'b1;
        repeat (3) tick();
        chk("halt_hold", {6'd0, o_halted, o_err, o_instr_cnt, snap},
            {6'd0, 1'b1, 1'b0, exp_cnt, 20'd0});

        // Execute timeout: ISZ never completes.
        do_reset();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 15; k++) exp_q.push_back(rec(3'd4, PH_EXM, S_ISZ));
        fetch_phase(16'h6010, 1'b0, 1'b0);
        repeat (15) tick();
        chk("timeout_err", {6'd0, o_halted, o_err, o_instr_cnt, snap}, {6'd0, 1'b0, 1'b1, 4'd0, 20'd0});
        i_ex_done = 1'b1;
        i_start   = 1'b1;
        repeat (2) tick();
        chk("err_sticky", {6'd0, o_halted, o_err, o_instr_cnt, snap}, {6'd0, 1'b0, 1'b1, 4'd0, 20'd0});

        chk("exp_queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
